// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg: shared types for the SSD1306 4-wire SPI transmitter.
//   state_e : transmitter FSM states
//   entry_t : one FIFO word, {dc, data}
package ssd1306_pkg;

    localparam int BITS_PER_BYTE = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_e;

    typedef struct packed {
        logic                     dc;
        logic [BITS_PER_BYTE-1:0] data;
    } entry_t;

endpackage

// File: rtl/tqv_sync_fifo.sv
// tqv_sync_fifo: single-clock FIFO with registered pointers.
//   clk, rst_n        : clock, async active-low reset (flushes pointers)
//   push_i, wdata_i   : write request / data (ignored when full)
//   pop_i, rdata_o    : read request / head-of-queue data (ignored when empty)
//   full_o, empty_o   : occupancy flags
// Pointers carry one extra MSB so full and empty can be told apart.
module tqv_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ssd1306_spi4_tx.sv
// ssd1306_spi4_tx: 4-wire SPI (mode 0, MSB first) transmitter for an SSD1306.
//   clk, rst_n          : clock, async active-low reset
//   tx_valid/tx_ready   : word handshake, tx_ready = !fifo_full
//   tx_data, tx_dc      : byte and D/C# flag (0=command, 1=display data)
//   busy_o              : FSM active or FIFO holding words
//   cs_o, sck_o, sdo_o, dc_o : registered SPI pins (CS# active low, SCLK idle low)
//
// state | meaning
// IDLE  | CS# high, waiting for a FIFO word
// SETUP | CS# low, first bit on SDIN, one half-period before first rise
// SHIFT | SCLK toggling; next byte chained at the 8th fall if one is queued
// HOLD  | SCLK low, one half-period before CS# rises
// GAP   | CS# high for CS_GAP half-periods, no pops
module ssd1306_spi4_tx
    import ssd1306_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_GAP     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_dc,
    output logic       busy_o,
    output logic       cs_o,
    output logic       sck_o,
    output logic       sdo_o,
    output logic       dc_o
);
    localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GC_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [HC_W-1:0] HC_LAST  = HC_W'(CLK_DIV - 1);
    localparam logic [GC_W-1:0] GC_LAST  = GC_W'(CS_GAP - 1);
    localparam logic [2:0]      BIT_LAST = 3'(BITS_PER_BYTE - 1);

    state_e          state_q, state_d;
    logic [HC_W-1:0] hc_q, hc_d;
    logic [GC_W-1:0] gc_q, gc_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            cs_q, cs_d;
    logic            sck_q, sck_d;
    logic            sdo_q, sdo_d;
    logic            dc_q, dc_d;
    logic            tick;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    entry_t          head;

    tqv_sync_fifo #(
        .WIDTH (BITS_PER_BYTE + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tx_valid),
        .wdata_i ({tx_dc, tx_data}),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign tx_ready = !fifo_full;
    assign busy_o   = (state_q != IDLE) || !fifo_empty;
    assign tick     = (hc_q == HC_LAST);
    assign cs_o     = cs_q;
    assign sck_o    = sck_q;
    assign sdo_o    = sdo_q;
    assign dc_o     = dc_q;

    always_comb begin
        state_d  = state_q;
        gc_d     = gc_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        cs_d     = cs_q;
        sck_d    = sck_q;
        sdo_d    = sdo_q;
        dc_d     = dc_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_d     = head.data;
                    sdo_d    = head.data[7];
                    dc_d     = head.dc;
                    cs_d     = 1'b0;
                    bit_d    = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    sck_d = !sck_q;
                    if (sck_q) begin
                        if (bit_q != BIT_LAST) begin
                            bit_d = bit_q + 1'b1;
                            // rotate rather than shift so every bit stays live
                            sh_d  = {sh_q[6:0], sh_q[7]};
                            sdo_d = sh_q[6];
                        end else if (!fifo_empty) begin
                            // chain the next byte inside the same CS# frame
                            fifo_pop = 1'b1;
                            sh_d     = head.data;
                            sdo_d    = head.data[7];
                            dc_d     = head.dc;
                            bit_d    = '0;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_d    = 1'b1;
                    gc_d    = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    if (gc_q == GC_LAST) state_d = IDLE;
                    else                 gc_d = gc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        hc_d = (tick || (state_d != state_q)) ? '0 : hc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hc_q    <= '0;
            gc_q    <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            sdo_q   <= 1'b0;
            dc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            gc_q    <= gc_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            sdo_q   <= sdo_d;
            dc_q    <= dc_d;
        end
    end

endmodule

// File: tb/tb_ssd1306_spi4_tx.sv
// tb_ssd1306_spi4_tx: directed and randomised bench for ssd1306_spi4_tx with
// a behavioural SPI sink that reassembles {dc,byte} words from the pins.
module tb_ssd1306_spi4_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = 8'h00;
    logic       tx_dc = 1'b0;
    logic       busy_o, cs_o, sck_o, sdo_o, dc_o;

    ssd1306_spi4_tx #(.CLK_DIV(2), .FIFO_DEPTH(4), .CS_GAP(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_dc    (tx_dc),
        .busy_o   (busy_o),
        .cs_o     (cs_o),
        .sck_o    (sck_o),
        .sdo_o    (sdo_o),
        .dc_o     (dc_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // sink model and pin monitor state
    logic       prev_cs = 1'b1, prev_sck = 1'b0, prev_dc = 1'b0;
    int         bitcnt = 0;
    logic [7:0] shin = 8'h00;
    logic       byte_dc = 1'b0;
    logic [8:0] rx_q[$];
    int         rise_q[$];
    int         cs_fall_cnt = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, last_fall_cyc = 0;
    int         dc_change_cnt = 0, dc_change_cyc = 0;
    int         viol = 0, dc_unstable = 0, min_gap = 1000000;
    bit         seen_cs_rise = 1'b0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst_n) begin
            bitcnt       = 0;
            seen_cs_rise = 1'b0;
        end else begin
            if ((cs_o != prev_cs) && (sck_o || prev_sck)) viol++;
            if (cs_o && prev_cs && (sck_o != prev_sck)) viol++;
            if (!cs_o && prev_cs) begin
                cs_fall_cnt++;
                cs_fall_cyc = cyc;
                if (seen_cs_rise && (cyc - cs_rise_cyc) < min_gap) min_gap = cyc - cs_rise_cyc;
            end
            if (cs_o && !prev_cs) begin
                cs_rise_cyc  = cyc;
                seen_cs_rise = 1'b1;
                bitcnt       = 0;
            end
            if (dc_o != prev_dc) begin
                dc_change_cnt++;
                dc_change_cyc = cyc;
            end
            if (!prev_sck && sck_o && !cs_o) begin
                rise_q.push_back(cyc);
                if (bitcnt == 0) byte_dc = dc_o;
                else if (dc_o != byte_dc) dc_unstable++;
                shin = {shin[6:0], sdo_o};
                bitcnt++;
                if (bitcnt == 8) begin
                    rx_q.push_back({byte_dc, shin});
                    bitcnt = 0;
                end
            end
            if (prev_sck && !sck_o) last_fall_cyc = cyc;
        end
        prev_cs  = cs_o;
        prev_sck = sck_o;
        prev_dc  = dc_o;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_word(input logic dc, input logic [7:0] d, output int waited);
        logic r;
        waited   = 0;
        tx_valid = 1'b1;
        tx_dc    = dc;
        tx_data  = d;
        forever begin
            r = tx_ready;
            @(posedge clk);
            #2;
            if (r) break;
            waited++;
            if (waited > 400) break;
        end
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((busy_o || !cs_o) && k < 3000) begin
            tick_n(1);
            k++;
        end
        tick_n(3);
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: busy_o=%b required 0", name, busy_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick_n(3);
        rst_n = 1'b1;
        tick_n(20);
        n_tests += 6;
        if (cs_o !== 1'b1)     begin n_fail++; $display("FAIL reset_cs: got %b required 1", cs_o); end
        if (sck_o !== 1'b0)    begin n_fail++; $display("FAIL reset_sck: got %b required 0", sck_o); end
        if (sdo_o !== 1'b0)    begin n_fail++; $display("FAIL reset_sdo: got %b required 0", sdo_o); end
        if (dc_o !== 1'b0)     begin n_fail++; $display("FAIL reset_dc: got %b required 0", dc_o); end
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", tx_ready); end
        if (busy_o !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy_o); end
    endtask

    task automatic test_single();
        int w, acc, f0;
        rise_q.delete();
        rx_q.delete();
        f0 = cs_fall_cnt;
        push_word(1'b0, 8'hAF, w);
        acc = cyc;
        wait_idle("single");
        n_tests += 5;
        if (cs_fall_cnt - f0 !== 1) begin n_fail++; $display("FAIL single_frames: got %0d required 1", cs_fall_cnt - f0); end
        if (cs_fall_cyc !== acc + 1) begin n_fail++; $display("FAIL single_cs_latency: got %0d required %0d", cs_fall_cyc - acc, 1); end
        if (rise_q.size() !== 8) begin n_fail++; $display("FAIL single_rises: got %0d required 8", rise_q.size()); end
        for (int i = 0; i < rise_q.size(); i++) begin
            n_tests++;
            if (rise_q[i] - cs_fall_cyc !== 4 * (i + 1)) begin
                n_fail++;
                $display("FAIL single_rise%0d_offset: got %0d required %0d", i, rise_q[i] - cs_fall_cyc, 4 * (i + 1));
            end
        end
        if (cs_rise_cyc - last_fall_cyc !== 2) begin n_fail++; $display("FAIL single_cs_release: got %0d required 2", cs_rise_cyc - last_fall_cyc); end
        if (rx_q.size() !== 1 || rx_q[0] !== 9'h0AF) begin
            n_fail++;
            $display("FAIL single_rx: got size %0d word %h required size 1 word 0af", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h1FF);
        end
    endtask

    task automatic test_back_to_back();
        int w, f0, d0;
        logic [8:0] exp[3];
        exp[0] = 9'h021; exp[1] = 9'h000; exp[2] = 9'h17F;
        rise_q.delete();
        rx_q.delete();
        f0 = cs_fall_cnt;
        d0 = dc_change_cnt;
        for (int i = 0; i < 3; i++) push_word(exp[i][8], exp[i][7:0], w);
        wait_idle("b2b");
        n_tests += 5;
        if (cs_fall_cnt - f0 !== 1) begin n_fail++; $display("FAIL b2b_frames: got %0d required 1", cs_fall_cnt - f0); end
        if (rise_q.size() !== 24) begin n_fail++; $display("FAIL b2b_rises: got %0d required 24", rise_q.size()); end
        if (rise_q.size() == 24) begin
            n_tests += 3;
            if (rise_q[8] - rise_q[0] !== 32)  begin n_fail++; $display("FAIL b2b_period1: got %0d required 32", rise_q[8] - rise_q[0]); end
            if (rise_q[16] - rise_q[8] !== 32) begin n_fail++; $display("FAIL b2b_period2: got %0d required 32", rise_q[16] - rise_q[8]); end
            if (dc_change_cyc !== rise_q[15] + 2) begin n_fail++; $display("FAIL b2b_dc_edge: got cycle %0d required %0d", dc_change_cyc, rise_q[15] + 2); end
        end
        if (dc_change_cnt - d0 !== 1) begin n_fail++; $display("FAIL b2b_dc_flips: got %0d required 1", dc_change_cnt - d0); end
        if (rx_q.size() !== 3) begin n_fail++; $display("FAIL b2b_rx_count: got %0d required 3", rx_q.size()); end
        for (int i = 0; i < rx_q.size() && i < 3; i++) begin
            n_tests++;
            if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_rx%0d: got %h required %h", i, rx_q[i], exp[i]); end
        end
    endtask

    task automatic test_stall();
        int w, lead;
        bit stalled;
        logic [8:0] exp[6];
        exp[0] = 9'h011; exp[1] = 9'h122; exp[2] = 9'h033;
        exp[3] = 9'h144; exp[4] = 9'h055; exp[5] = 9'h166;
        rx_q.delete();
        lead = 0;
        stalled = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_word(exp[i][8], exp[i][7:0], w);
            if (w != 0) stalled = 1'b1;
            if (!stalled) lead++;
            if (i == 4) begin
                n_tests++;
                if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_low: got %b required 0", tx_ready); end
            end
        end
        wait_idle("stall");
        n_tests += 2;
        if (lead !== 5) begin n_fail++; $display("FAIL stall_accepted_before_full: got %0d required 5", lead); end
        if (rx_q.size() !== 6) begin n_fail++; $display("FAIL stall_rx_count: got %0d required 6", rx_q.size()); end
        for (int i = 0; i < rx_q.size() && i < 6; i++) begin
            n_tests++;
            if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL stall_rx%0d: got %h required %h", i, rx_q[i], exp[i]); end
        end
    endtask

    task automatic test_late_push();
        int w, f0, k;
        rx_q.delete();
        rise_q.delete();
        f0 = cs_fall_cnt;
        push_word(1'b0, 8'h3C, w);
        k = 0;
        while (rise_q.size() < 8 && k < 200) begin tick_n(1); k++; end
        tick_n(3);
        push_word(1'b1, 8'hC3, w);
        wait_idle("late");
        n_tests += 3;
        if (cs_fall_cnt - f0 !== 2) begin n_fail++; $display("FAIL late_frames: got %0d required 2", cs_fall_cnt - f0); end
        if (rx_q.size() !== 2) begin n_fail++; $display("FAIL late_rx_count: got %0d required 2", rx_q.size()); end
        if (rx_q.size() == 2 && (rx_q[0] !== 9'h03C || rx_q[1] !== 9'h1C3)) begin
            n_fail++;
            $display("FAIL late_rx_words: got %h %h required 03c 1c3", rx_q[0], rx_q[1]);
        end
    endtask

    task automatic test_reset_mid_byte();
        int w, k;
        rx_q.delete();
        rise_q.delete();
        push_word(1'b1, 8'hAB, w);
        k = 0;
        while (rise_q.size() < 3 && k < 200) begin tick_n(1); k++; end
        tick_n(1);
        rst_n = 1'b0;
        #1;
        n_tests += 5;
        if (cs_o !== 1'b1)   begin n_fail++; $display("FAIL midrst_cs: got %b required 1", cs_o); end
        if (sck_o !== 1'b0)  begin n_fail++; $display("FAIL midrst_sck: got %b required 0", sck_o); end
        if (sdo_o !== 1'b0)  begin n_fail++; $display("FAIL midrst_sdo: got %b required 0", sdo_o); end
        if (dc_o !== 1'b0)   begin n_fail++; $display("FAIL midrst_dc: got %b required 0", dc_o); end
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b required 0", busy_o); end
        tick_n(2);
        rst_n = 1'b1;
        tick_n(2);
        n_tests += 2;
        if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b required 1", tx_ready); end
        if (rx_q.size() !== 0) begin n_fail++; $display("FAIL midrst_partial: got %0d words required 0", rx_q.size()); end
        push_word(1'b0, 8'h55, w);
        wait_idle("midrst");
        n_tests++;
        if (rx_q.size() !== 1 || rx_q[0] !== 9'h055) begin
            n_fail++;
            $display("FAIL midrst_clean_byte: got size %0d word %h required size 1 word 055", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h1FF);
        end
    endtask

    task automatic test_random();
        logic [8:0] exp_q[$];
        logic [8:0] word;
        int w, gap, timeouts, bad;
        rx_q.delete();
        min_gap  = 1000000;
        timeouts = 0;
        for (int i = 0; i < 500; i++) begin
            gap = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(30, 60);
            tick_n(gap);
            word = 9'($urandom_range(0, 511));
            push_word(word[8], word[7:0], w);
            if (w > 400) timeouts++;
            else exp_q.push_back(word);
        end
        wait_idle("rand");
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            if (rx_q[i] !== exp_q[i]) bad++;
        n_tests += 5;
        if (timeouts !== 0) begin n_fail++; $display("FAIL rand_push_timeouts: got %0d required 0", timeouts); end
        if (rx_q.size() !== 500) begin n_fail++; $display("FAIL rand_rx_count: got %0d required 500", rx_q.size()); end
        if (bad !== 0) begin n_fail++; $display("FAIL rand_rx_words: got %0d mismatching required 0", bad); end
        if (min_gap < 2) begin n_fail++; $display("FAIL rand_cs_gap: got %0d clk required >= 2", min_gap); end
        if (min_gap == 1000000) begin n_fail++; $display("FAIL rand_frames: got no frame gap observed required at least one"); end
    endtask

    task automatic test_protocol();
        n_tests += 2;
        if (viol !== 0)        begin n_fail++; $display("FAIL proto_sck_cs: got %0d violations required 0", viol); end
        if (dc_unstable !== 0) begin n_fail++; $display("FAIL proto_dc_stable: got %0d violations required 0", dc_unstable); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_late_push();
        test_reset_mid_byte();
        test_random();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
